// File: rtl/mem_model_arb_pkg.sv
// Shared types for the two-manager Avalon-MM burst arbiter in front of mem_model.
// Holds the FSM states, the read return-queue entry and burstcount normalisation.
package mem_model_arb_pkg;

  localparam int BW = 12;

  typedef enum logic {
    IDLE   = 1'b0,
    WBURST = 1'b1
  } arb_state_e;

  // One outstanding read burst: issuing manager and its beat count.
  typedef struct packed {
    logic          id;
    logic [BW-1:0] count;
  } rdq_entry_t;

  function automatic logic [BW-1:0] norm_burst(input logic [BW-1:0] bc);
    return (bc == '0) ? BW'(1) : bc;
  endfunction

endpackage

// File: rtl/mem_model_avm_arb_if.sv
// Bus bundle of the arbiter: both manager ports (packed per manager) and the mem_model port.
// slave is the arbiter's view; master is the environment (managers plus memory).
interface mem_model_avm_arb_if #(
  parameter int ADDRWIDTH  = 32,
  parameter int DATAWIDTH  = 32,
  parameter int BURSTWIDTH = 12
);
  logic [2*ADDRWIDTH-1:0]   m_address;
  logic [2*DATAWIDTH/8-1:0] m_byteenable;
  logic [1:0]               m_write;
  logic [2*DATAWIDTH-1:0]   m_writedata;
  logic [1:0]               m_read;
  logic [2*BURSTWIDTH-1:0]  m_burstcount;
  logic [1:0]               m_waitrequest;
  logic [DATAWIDTH-1:0]     m_readdata;
  logic [1:0]               m_readdatavalid;

  logic [ADDRWIDTH-1:0]     s_address;
  logic [DATAWIDTH/8-1:0]   s_byteenable;
  logic                     s_write;
  logic [DATAWIDTH-1:0]     s_writedata;
  logic                     s_read;
  logic [BURSTWIDTH-1:0]    s_burstcount;
  logic                     s_waitrequest;
  logic [DATAWIDTH-1:0]     s_readdata;
  logic                     s_readdatavalid;

  modport slave (
    input  m_address, m_byteenable, m_write, m_writedata, m_read, m_burstcount,
    output m_waitrequest, m_readdata, m_readdatavalid,
    output s_address, s_byteenable, s_write, s_writedata, s_read, s_burstcount,
    input  s_waitrequest, s_readdata, s_readdatavalid
  );

  modport master (
    output m_address, m_byteenable, m_write, m_writedata, m_read, m_burstcount,
    input  m_waitrequest, m_readdata, m_readdatavalid,
    input  s_address, s_byteenable, s_write, s_writedata, s_read, s_burstcount,
    output s_waitrequest, s_readdata, s_readdatavalid
  );
endinterface

// File: rtl/mem_model_q.sv
// Small synchronous FIFO used as the in-order read return queue of the arbiter.
// DEPTH must be a power of two (>= 2); push when full and pop when empty are ignored.
module mem_model_q #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/mem_model_avm_arb.sv
// Round-robin arbiter sharing one mem_model burst port between two Avalon-MM managers.
// Write bursts lock the grant; read issuers are queued so returned beats are steered back.
module mem_model_avm_arb
  import mem_model_arb_pkg::*;
#(
  parameter int ADDRWIDTH  = 32,
  parameter int DATAWIDTH  = 32,
  parameter int BURSTWIDTH = BW,
  parameter int RDQ_DEPTH  = 8
) (
  input  logic               clk,
  input  logic               nreset,
  mem_model_avm_arb_if.slave bus,
  output logic               rdq_err
);
  localparam int BEW = DATAWIDTH / 8;

  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [BURSTWIDTH-1:0] wcnt_q, wcnt_d;
  logic [BURSTWIDTH-1:0] rbeat_q, rbeat_d;
  logic                  rdq_err_q, rdq_err_d;

  logic [1:0]            rd_ok, elig;
  logic                  gnt_vld, gnt;
  logic [BURSTWIDTH-1:0] gnt_burst;
  logic                  accept, rvalid;
  logic                  rdq_push, rdq_pop, rdq_empty, rdq_full;
  rdq_entry_t            push_entry, head;

  // Write wins over a simultaneous read; a full return queue masks reads.
  assign rd_ok = bus.m_read & ~bus.m_write & {2{~rdq_full}};
  assign elig  = bus.m_write | rd_ok;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    if (!nreset) begin
      gnt_vld = 1'b0;
    end else if (state_q == WBURST) begin
      gnt_vld = 1'b1;
      gnt     = owner_q;
    end else if (elig == 2'b11) begin
      gnt_vld = 1'b1;
      gnt     = ~last_grant_q;
    end else if (elig != 2'b00) begin
      gnt_vld = 1'b1;
      gnt     = elig[1];
    end
  end

  assign bus.s_address    = gnt ? bus.m_address[2*ADDRWIDTH-1:ADDRWIDTH]
                                : bus.m_address[ADDRWIDTH-1:0];
  assign bus.s_byteenable = gnt ? bus.m_byteenable[2*BEW-1:BEW]
                                : bus.m_byteenable[BEW-1:0];
  assign bus.s_writedata  = gnt ? bus.m_writedata[2*DATAWIDTH-1:DATAWIDTH]
                                : bus.m_writedata[DATAWIDTH-1:0];
  assign bus.s_burstcount = gnt ? bus.m_burstcount[2*BURSTWIDTH-1:BURSTWIDTH]
                                : bus.m_burstcount[BURSTWIDTH-1:0];
  assign gnt_burst        = norm_burst(bus.s_burstcount);

  assign bus.s_write = gnt_vld && bus.m_write[gnt];
  assign bus.s_read  = gnt_vld && (state_q == IDLE) && rd_ok[gnt];
  assign accept      = (bus.s_write || bus.s_read) && !bus.s_waitrequest;

  always_comb begin
    bus.m_waitrequest = 2'b11;
    if (gnt_vld) bus.m_waitrequest[gnt] = bus.s_waitrequest;
  end

  // Read return path: the queue head names the manager owning the current beat.
  assign rvalid              = nreset && bus.s_readdatavalid && !rdq_empty;
  assign bus.m_readdatavalid = {rvalid && head.id, rvalid && !head.id};
  assign bus.m_readdata      = bus.s_readdata;
  assign rdq_pop             = rvalid && (rbeat_q == head.count - BURSTWIDTH'(1));
  assign rdq_push            = bus.s_read && !bus.s_waitrequest;
  assign push_entry          = '{id: gnt, count: gnt_burst};
  assign rdq_err             = rdq_err_q;

  mem_model_q #(
    .WIDTH (1 + BURSTWIDTH),
    .DEPTH (RDQ_DEPTH)
  ) u_rdq (
    .clk         (clk),
    .nreset      (nreset),
    .push_i      (rdq_push),
    .push_data_i (push_entry),
    .pop_i       (rdq_pop),
    .head_o      (head),
    .empty_o     (rdq_empty),
    .full_o      (rdq_full)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wcnt_d       = wcnt_q;
    rbeat_d      = rbeat_q;
    rdq_err_d    = rdq_err_q || (bus.s_readdatavalid && rdq_empty);
    if (accept) begin
      if (state_q == IDLE) begin
        last_grant_d = gnt;
        if (bus.s_write && gnt_burst != BURSTWIDTH'(1)) begin
          state_d = WBURST;
          owner_d = gnt;
          wcnt_d  = gnt_burst - BURSTWIDTH'(1);
        end
      end else begin
        wcnt_d = wcnt_q - BURSTWIDTH'(1);
        if (wcnt_q == BURSTWIDTH'(1)) state_d = IDLE;
      end
    end
    if (rvalid) rbeat_d = rdq_pop ? '0 : rbeat_q + BURSTWIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      wcnt_q       <= '0;
      rbeat_q      <= '0;
      rdq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wcnt_q       <= wcnt_d;
      rbeat_q      <= rbeat_d;
      rdq_err_q    <= rdq_err_d;
    end
  end

endmodule

// File: tb/tb_mem_model_avm_arb.sv
// Directed bench for mem_model_avm_arb with a small behavioural memory behind the s_* port.
// Inputs change 1 ns after the rising edge; outputs are sampled 4 ns after it.
module tb_mem_model_avm_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 12;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic rdq_err;
  always #5 clk = ~clk;

  mem_model_avm_arb_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .BURSTWIDTH(BW)) bus ();

  mem_model_avm_arb #(
    .ADDRWIDTH (AW),
    .DATAWIDTH (DW),
    .BURSTWIDTH(BW),
    .RDQ_DEPTH (8)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave),
    .rdq_err(rdq_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural memory: fixed 2-cycle read latency, one beat per cycle, optional hold.
  typedef struct {
    logic [31:0] data;
    int          due;
  } beat_t;

  logic [31:0] mem [logic [31:0]];
  beat_t       pend[$];
  logic [31:0] rlog0[$];
  logic [31:0] rlog1[$];
  int          rid_log[$];
  int          cyc_cnt = 0;
  int          wleft = 0;
  logic [31:0] waddr = '0;
  bit          rd_hold = 1'b0;
  bit          spur = 1'b0;

  function automatic int nb(input logic [BW-1:0] b);
    return (b == '0) ? 1 : int'(b);
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always begin
    @(posedge clk);
    cyc_cnt++;
    if (!nreset) begin
      wleft = 0;
      pend.delete();
    end else begin
      if (bus.s_write && !bus.s_waitrequest) begin
        if (wleft == 0) begin
          waddr = bus.s_address;
          wleft = nb(bus.s_burstcount);
        end
        mem[waddr] = bus.s_writedata;
        waddr += 32'd4;
        wleft--;
      end
      if (bus.s_read && !bus.s_waitrequest) begin
        for (int k = 0; k < nb(bus.s_burstcount); k++)
          pend.push_back('{data: rd_mem(bus.s_address + 32'(4 * k)), due: cyc_cnt + 2});
      end
      if (bus.m_readdatavalid[0]) begin rlog0.push_back(bus.m_readdata); rid_log.push_back(0); end
      if (bus.m_readdatavalid[1]) begin rlog1.push_back(bus.m_readdata); rid_log.push_back(1); end
    end
    #2;
    if (spur) begin
      bus.s_readdatavalid = 1'b1;
      bus.s_readdata      = 32'hDEAD_BEEF;
    end else if (!rd_hold && pend.size() > 0 && pend[0].due <= cyc_cnt) begin
      bus.s_readdatavalid = 1'b1;
      bus.s_readdata      = pend[0].data;
      void'(pend.pop_front());
    end else begin
      bus.s_readdatavalid = 1'b0;
      bus.s_readdata      = '0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input bit w, input bit r, input logic [31:0] addr,
                       input logic [31:0] data, input logic [BW-1:0] bc);
    bus.m_write[id]               = w;
    bus.m_read[id]                = r;
    bus.m_address[id*AW +: AW]    = addr;
    bus.m_writedata[id*DW +: DW]  = data;
    bus.m_burstcount[id*BW +: BW] = bc;
    bus.m_byteenable[id*4 +: 4]   = 4'hF;
  endtask

  task automatic clr_logs();
    rlog0.delete();
    rlog1.delete();
    rid_log.delete();
  endtask

  // Hold a read request until the arbiter accepts it (bounded).
  task automatic rd_issue(input int id, input logic [31:0] addr, input logic [BW-1:0] bc);
    bit done = 1'b0;
    drive(id, 1'b0, 1'b1, addr, 32'h0, bc);
    for (int k = 0; k < 20 && !done; k++) begin
      #3;
      if (!bus.m_waitrequest[id]) done = 1'b1;
      cyc();
    end
    bus.m_read[id] = 1'b0;
    check("rd_accept", 32'(done), 32'd1);
  endtask

  task automatic wait_beats(input string tag, input int n0, input int n1);
    int k = 0;
    while ((rlog0.size() < n0 || rlog1.size() < n1) && k < 200) begin
      cyc();
      k++;
    end
    repeat (3) cyc();
    check({tag, "_beats_m0"}, 32'(rlog0.size()), 32'(n0));
    check({tag, "_beats_m1"}, 32'(rlog1.size()), 32'(n1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [31:0] t2_exp[4]  = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
    bit          t2_pat[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] t3_exp0[3] = '{32'hD000_0000, 32'hD000_0004, 32'hD000_0008};
    logic [31:0] t3_exp1[2] = '{32'hD000_0040, 32'hD000_0044};
    int          t3_ids[5]  = '{0, 0, 0, 1, 1};
    int          beat;
    int          k;

    bus.m_address = '0; bus.m_byteenable = '0; bus.m_write = '0; bus.m_writedata = '0;
    bus.m_read = '0; bus.m_burstcount = '0; bus.s_waitrequest = 1'b0;
    bus.s_readdatavalid = 1'b0; bus.s_readdata = '0;
    for (int a = 0; a < 32; a++) mem[32'(4 * a)] = 32'hD000_0000 + 32'(4 * a);

    // Reset: outputs quiet even with a manager requesting.
    repeat (3) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h1, 1);
    #3;
    check("rst_waitreq", bus.m_waitrequest, 2'b11);
    check("rst_s_write", bus.s_write, 1'b0);
    check("rst_s_read", bus.s_read, 1'b0);
    check("rst_rdv", bus.m_readdatavalid, 2'b00);
    check("rst_rdq_err", rdq_err, 1'b0);
    cyc();
    bus.m_write = '0;
    nreset = 1'b1;
    cyc();

    // T1: simultaneous single writes, m0 wins the first tie.
    drive(0, 1'b1, 1'b0, 32'h100, 32'hA5A5_A5A5, 1);
    drive(1, 1'b1, 1'b0, 32'h200, 32'h5A5A_5A5A, 1);
    #3;
    check("t1_first_m0", bus.m_waitrequest, 2'b10);
    check("t1_s_addr", bus.s_address, 32'h100);
    cyc();
    bus.m_write[0] = 1'b0;
    #3;
    check("t1_then_m1", bus.m_waitrequest, 2'b01);
    cyc();
    bus.m_write = '0;
    clr_logs();
    rd_issue(0, 32'h100, 1);
    rd_issue(1, 32'h200, 1);
    wait_beats("t1", 1, 1);
    check("t1_rd_100", rlog0[0], 32'hA5A5_A5A5);
    check("t1_rd_200", rlog1[0], 32'h5A5A_5A5A);

    // T2: m0 burst of 4 with a gap cycle; m1 held for the whole burst.
    beat = 0;
    drive(0, 1'b1, 1'b0, 32'h400, 32'h1111_0000, 4);
    drive(1, 1'b1, 1'b0, 32'h500, 32'hBEEF_0001, 1);
    for (int c = 0; c < 5; c++) begin
      bus.m_write[0]         = t2_pat[c];
      bus.m_writedata[31:0]  = 32'h1111_0000 + 32'(beat);
      #3;
      if (c == 0) check("t2_m0_first", bus.m_waitrequest[0], 1'b0);
      check("t2_m1_held", bus.m_waitrequest[1], 1'b1);
      if (t2_pat[c]) beat++;
      cyc();
    end
    bus.m_write[0] = 1'b0;
    #3;
    check("t2_m1_granted", bus.m_waitrequest, 2'b01);
    check("t2_m1_addr", bus.s_address, 32'h500);
    cyc();
    bus.m_write = '0;
    clr_logs();
    rd_issue(0, 32'h400, 4);
    rd_issue(1, 32'h500, 1);
    wait_beats("t2", 4, 1);
    for (int i = 0; i < 4; i++) check("t2_burst_data", rlog0[i], t2_exp[i]);
    check("t2_m1_data", rlog1[0], 32'hBEEF_0001);

    // T5: both managers hammering single writes alternate grants.
    drive(0, 1'b1, 1'b0, 32'h700, 32'h70, 1);
    drive(1, 1'b1, 1'b0, 32'h780, 32'h78, 1);
    for (int i = 0; i < 10; i++) begin
      #3;
      check("t5_alternate", bus.m_waitrequest, (i % 2 == 0) ? 2'b10 : 2'b01);
      cyc();
    end
    bus.m_write = '0;

    // T3: interleaved read bursts return strictly in order.
    clr_logs();
    rd_issue(0, 32'h0, 3);
    rd_issue(1, 32'h40, 2);
    wait_beats("t3", 3, 2);
    for (int i = 0; i < 5; i++) check("t3_order", 32'(rid_log[i]), 32'(t3_ids[i]));
    for (int i = 0; i < 3; i++) check("t3_m0_data", rlog0[i], t3_exp0[i]);
    for (int i = 0; i < 2; i++) check("t3_m1_data", rlog1[i], t3_exp1[i]);

    // T4: nine reads with data held back; the ninth waits for a free queue slot.
    clr_logs();
    rd_hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b0, 1'b1, 32'(4 * i), 32'h0, 1);
      #3;
      check("t4_accept", bus.m_waitrequest[0], 1'b0);
      cyc();
    end
    drive(0, 1'b0, 1'b1, 32'h20, 32'h0, 1);
    #3;
    check("t4_full_stall", bus.m_waitrequest[0], 1'b1);
    repeat (3) cyc();
    #3;
    check("t4_still_stall", bus.m_waitrequest[0], 1'b1);
    rd_hold = 1'b0;
    k = 0;
    do begin
      cyc();
      #3;
      k++;
    end while (bus.m_waitrequest[0] && k < 20);
    check("t4_unstall", bus.m_waitrequest[0], 1'b0);
    cyc();
    bus.m_read[0] = 1'b0;
    wait_beats("t4", 9, 0);
    check("t4_first_data", rlog0[0], 32'hD000_0000);
    check("t4_ninth_data", rlog0[8], 32'hD000_0020);

    // T6: reset in the middle of a write burst, then a fresh m1 write.
    drive(0, 1'b1, 1'b0, 32'h600, 32'h6666_0000, 4);
    #3;
    check("t6_beat1", bus.m_waitrequest[0], 1'b0);
    cyc();
    bus.m_writedata[31:0] = 32'h6666_0001;
    cyc();
    nreset = 1'b0;
    drive(1, 1'b1, 1'b0, 32'h300, 32'hC0FF_EE00, 1);
    #3;
    check("t6_rst_waitreq", bus.m_waitrequest, 2'b11);
    check("t6_rst_s_write", bus.s_write, 1'b0);
    check("t6_rst_rdv", bus.m_readdatavalid, 2'b00);
    cyc();
    cyc();
    nreset = 1'b1;
    bus.m_write[0] = 1'b0;
    #3;
    check("t6_m1_granted", bus.m_waitrequest, 2'b01);
    check("t6_rdq_err", rdq_err, 1'b0);
    check("t6_rdv", bus.m_readdatavalid, 2'b00);
    cyc();
    bus.m_write = '0;
    clr_logs();
    rd_issue(1, 32'h300, 1);
    wait_beats("t6", 0, 1);
    check("t6_rd_300", rlog1[0], 32'hC0FF_EE00);

    // T7: read data with an empty return queue is dropped and flagged.
    spur = 1'b1;
    #3;
    check("t7_dropped", bus.m_readdatavalid, 2'b00);
    check("t7_err_before", rdq_err, 1'b0);
    cyc();
    spur = 1'b0;
    #3;
    check("t7_err_set", rdq_err, 1'b1);
    repeat (3) cyc();
    #3;
    check("t7_err_sticky", rdq_err, 1'b1);
    cyc();

    // T8: burstcount 0 behaves as a single beat; no lock, one read beat.
    drive(0, 1'b1, 1'b0, 32'h800, 32'h88, 0);
    drive(1, 1'b1, 1'b0, 32'h880, 32'h89, 1);
    #3;
    check("t8_m0_first", bus.m_waitrequest, 2'b10);
    cyc();
    #3;
    check("t8_no_lock", bus.m_waitrequest, 2'b01);
    cyc();
    bus.m_write = '0;
    clr_logs();
    rd_issue(0, 32'h800, 0);
    wait_beats("t8", 1, 0);
    check("t8_rd_800", rlog0[0], 32'h88);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_model_avm_arb.md
Name: mem_model_avm_arb

Overview:
- Two-manager Avalon-MM burst arbiter that shares one mem_model burst port (tx/rx) between two requesters, e.g. two mem_model_axi front ends or a test manager plus the AXI wrapper.
- Grants command access round-robin and locks the grant for the full length of a write burst.
- Records the issuer of each read in an in-order return queue so each read-data beat is steered back to the manager that issued the read.

Parameters:
- ADDRWIDTH, 32: address width.
- DATAWIDTH, 32: data width; byteenable width is DATAWIDTH/8.
- BURSTWIDTH, 12: burstcount width, matching mem_model.
- RDQ_DEPTH, 8: maximum outstanding read bursts, power of 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- nreset  input  1  synchronous, active-low reset.
- m_address  input  2*ADDRWIDTH  manager i at [i*ADDRWIDTH +: ADDRWIDTH].
- m_byteenable  input  2*DATAWIDTH/8  per-manager byte enables.
- m_write  input  2  per-manager write request.
- m_writedata  input  2*DATAWIDTH  per-manager write data.
- m_read  input  2  per-manager read request.
- m_burstcount  input  2*BURSTWIDTH  per-manager burst length.
- m_waitrequest  output  2  per-manager stall.
- m_readdata  output  DATAWIDTH  s_readdata broadcast to both managers.
- m_readdatavalid  output  2  per-manager read-data valid.
- s_address  output  ADDRWIDTH  to mem_model.
- s_byteenable  output  DATAWIDTH/8  to mem_model.
- s_write  output  1  to mem_model.
- s_writedata  output  DATAWIDTH  to mem_model.
- s_read  output  1  to mem_model.
- s_burstcount  output  BURSTWIDTH  to mem_model.
- s_waitrequest  input  1  from mem_model.
- s_readdata  input  DATAWIDTH  from mem_model.
- s_readdatavalid  input  1  from mem_model.
- rdq_err  output  1  sticky: read data arrived with the return queue empty.

Behaviour:
- Reset (nreset=0 at a clock edge):
  - state=IDLE, last_grant=1 (manager 0 wins the first tie), beat counter=0, return queue empty, rdq_err=0.
  - While nreset=0: m_readdatavalid=0, s_write=0, s_read=0, m_waitrequest=2'b11.
  - Reset mid-burst abandons the burst; no response is generated.
- Manager request: req[i] = m_write[i] | m_read[i]. If a manager asserts both, the write is used and its read is ignored.
- A read request is eligible only when the return queue is not full; a full queue masks that manager's read.
- IDLE grant is combinational, in the same cycle as the request:
  - Only one manager eligible: that manager is granted.
  - Both eligible: grant the manager other than last_grant.
- The granted manager's signals drive s_*. m_waitrequest for the granted manager equals s_waitrequest; for the other manager it is 1. With no grant, s_read=s_write=0.
- Accept means s_write or s_read is high and s_waitrequest=0. last_grant updates on the first accepted beat or command only.
- Burstcount 0 is treated as 1, both for write locking and for return-queue beat counts.
- Write burst of N beats:
  - First beat accepted and N>1: move to WBURST, counter=N-1, grant locked to that manager.
  - Each accepted beat in WBURST decrements the counter. Return to IDLE on the beat that makes the counter 0.
  - In WBURST the other manager is held off even if the owner deasserts m_write.
- Read command:
  - Accepted in a single cycle; state stays IDLE.
  - Pushes {id, burstcount} into the return queue.
  - A read from the other manager may be granted the next cycle.
- Read return:
  - Each s_readdatavalid asserts m_readdatavalid[head.id] in the same cycle (combinational).
  - The head's beat counter decrements per beat; the entry is popped on its last beat.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- s_readdatavalid with the return queue empty: the beat is dropped (no m_readdatavalid) and rdq_err is set; rdq_err clears only on reset.
- Return data is strictly in order across managers. mem_model's in-order return guarantees correctness.

Decomposition:
- Package mem_model_arb_pkg holds:
  - state encoding (IDLE, WBURST);
  - return-queue entry layout {id:1, count:BURSTWIDTH};
  - function normalising burstcount 0 to 1.
- Sub-module mem_model_q serves as the return queue (WIDTH=1+BURSTWIDTH, DEPTH=RDQ_DEPTH); its full output gates read eligibility.

Test Plan:
- m0 and m1 each request a single write in the same cycle after reset -> m0 is accepted first, then m1; addresses 0x100 and 0x200 read back 0xA5A5A5A5 and 0x5A5A5A5A.
- m0 write burstcount=4 while m1 requests a write throughout -> m1's m_waitrequest=1 for all 4 m0 beats (including an m0 gap cycle); m1 is granted the cycle after m0's 4th beat.
- Interleaved reads: m0 burst of 3 at 0x0, then m1 burst of 2 at 0x40 -> exactly 3 m_readdatavalid[0] beats, then 2 m_readdatavalid[1] beats, with matching data.
- Nine back-to-back m0 single reads with s_readdatavalid delayed (RDQ_DEPTH=8) -> the 9th read stalls (m_waitrequest[0]=1) until the first beat returns; all 9 beats delivered.
- Both managers continuously requesting single writes for 10 cycles with s_waitrequest=0 -> grants alternate m0,m1,m0,...
- nreset low mid write burst (beat 2 of 4), then a fresh m1 single write at 0x300 -> state IDLE, rdq_err=0, m_readdatavalid=0; the m1 write is granted and 0x300 reads back its data.
